// File: rtl/cal_kl_elastic.sv
// Backward-extension k/l calculation stage with valid/ready handshakes.
// S1 precomputes the candidate occurrence indices; S2 picks k/l against the
// BWT primary, forms occ-line request addresses and counts memory lines.
module cal_kl_elastic #(
  parameter int IDX_W     = 64,
  parameter int ADDR_W    = 42,
  parameter int OCC_SHIFT = 7,
  parameter int IDX_HI    = 34,
  parameter int LINE_BITS = 4,
  parameter int READ_W    = 8,
  parameter int SIDE_W    = 160,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_status,
  input  logic              in_finish,
  input  logic [READ_W-1:0] in_read_num,
  input  logic [IDX_W-1:0]  in_x0,
  input  logic [IDX_W-1:0]  in_x2,
  input  logic [IDX_W-1:0]  in_primary,
  input  logic [6:0]        in_bwd_i,
  input  logic [6:0]        in_mem_wr_addr,
  input  logic [SIDE_W-1:0] in_side,
  output logic              qry_valid,
  output logic [READ_W-1:0] qry_read_num,
  output logic [6:0]        qry_pos,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        out_status,
  output logic              out_finish,
  output logic [READ_W-1:0] out_read_num,
  output logic [IDX_W-1:0]  out_k,
  output logic [IDX_W-1:0]  out_l,
  output logic [ADDR_W-1:0] out_addr_k,
  output logic [ADDR_W-1:0] out_addr_l,
  output logic              out_req_valid,
  output logic              out_same_line,
  output logic [6:0]        out_mem_size,
  output logic [SIDE_W-1:0] out_side,
  output logic [CNT_W-1:0]  req_count
);

  localparam logic [5:0] ST_BUBBLE  = 6'h00;
  localparam logic [5:0] ST_BCK_INI = 6'h08;
  localparam logic [5:0] ST_BCK_RUN = 6'h10;
  localparam logic [5:0] ST_BCK_END = 6'h20;

  // S1 state
  logic              r_s1_v;
  logic [IDX_W-1:0]  r_s1_kt, r_s1_lt, r_s1_kt1, r_s1_lt1, r_s1_primary;
  logic [5:0]        r_s1_status;
  logic [READ_W-1:0] r_s1_read_num;
  logic [6:0]        r_s1_mem_size;
  logic [SIDE_W-1:0] r_s1_side;

  // S2 state (drives the outputs directly)
  logic              r_s2_v;
  logic [5:0]        r_status;
  logic              r_finish;
  logic [READ_W-1:0] r_read_num;
  logic [IDX_W-1:0]  r_k, r_l;
  logic [ADDR_W-1:0] r_addr_k, r_addr_l;
  logic              r_req_valid, r_same_line;
  logic [6:0]        r_mem_size;
  logic [SIDE_W-1:0] r_side;
  logic [CNT_W-1:0]  r_req_count;

  logic              r_qry_v;
  logic [READ_W-1:0] r_qry_read_num;
  logic [6:0]        r_qry_pos;

  logic              w_s2_free, w_accept, w_keep;
  logic [5:0]        w_eff_status;
  logic [IDX_W-1:0]  w_k, w_l;
  logic [ADDR_W-1:0] w_addr_k, w_addr_l;
  logic [CNT_W:0]    w_cnt_sum;

  assign w_s2_free    = !r_s2_v || out_ready;
  assign in_ready     = !r_s1_v || w_s2_free;
  assign w_accept     = in_valid && in_ready;
  // A finished read is turned into an end token regardless of its status code
  assign w_eff_status = in_finish ? ST_BCK_END : in_status;
  assign w_keep       = (w_eff_status == ST_BCK_INI) || (w_eff_status == ST_BCK_RUN) ||
                        (w_eff_status == ST_BCK_END);

  // Wrap past the primary row: the sentinel slot is skipped, hence the -2 variant
  always_comb begin
    w_k      = (r_s1_kt >= r_s1_primary) ? r_s1_kt1 : r_s1_kt;
    w_l      = (r_s1_lt >= r_s1_primary) ? r_s1_lt1 : r_s1_lt;
    w_addr_k = ADDR_W'({w_k[IDX_HI:OCC_SHIFT], {LINE_BITS{1'b0}}});
    w_addr_l = ADDR_W'({w_l[IDX_HI:OCC_SHIFT], {LINE_BITS{1'b0}}});
  end

  // A merged request costs one line, otherwise two
  assign w_cnt_sum = {1'b0, r_req_count} + (r_same_line ? (CNT_W+1)'(1) : (CNT_W+1)'(2));

  // S1: capture kept tokens and precompute both candidate index pairs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_v        <= 1'b0;
      r_s1_kt       <= '0;
      r_s1_lt       <= '0;
      r_s1_kt1      <= '0;
      r_s1_lt1      <= '0;
      r_s1_primary  <= '0;
      r_s1_status   <= ST_BUBBLE;
      r_s1_read_num <= '0;
      r_s1_mem_size <= '0;
      r_s1_side     <= '0;
    end else begin
      r_s1_v <= w_accept ? w_keep : (r_s1_v && !w_s2_free);
      if (w_accept && w_keep) begin
        r_s1_kt       <= in_x0 - IDX_W'(1);
        r_s1_lt       <= in_x0 - IDX_W'(1) + in_x2;
        r_s1_kt1      <= in_x0 - IDX_W'(2);
        r_s1_lt1      <= in_x0 - IDX_W'(2) + in_x2;
        r_s1_primary  <= in_primary;
        r_s1_status   <= w_eff_status;
        r_s1_read_num <= in_read_num;
        r_s1_mem_size <= in_mem_wr_addr;
        r_s1_side     <= in_side;
      end
    end
  end

  // Query-ahead pulse one cycle after a kept token is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_qry_v        <= 1'b0;
      r_qry_read_num <= '0;
      r_qry_pos      <= '0;
    end else begin
      r_qry_v <= w_accept && w_keep;
      if (w_accept && w_keep) begin
        r_qry_read_num <= in_read_num;
        r_qry_pos      <= in_bwd_i;
      end
    end
  end

  // S2: select k/l, build request addresses, shape the output token
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_v      <= 1'b0;
      r_status    <= ST_BUBBLE;
      r_finish    <= 1'b0;
      r_read_num  <= '0;
      r_k         <= '0;
      r_l         <= '0;
      r_addr_k    <= '0;
      r_addr_l    <= '0;
      r_req_valid <= 1'b0;
      r_same_line <= 1'b0;
      r_mem_size  <= '0;
      r_side      <= '0;
    end else if (w_s2_free) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_read_num <= r_s1_read_num;
        if (r_s1_status == ST_BCK_END) begin
          r_status    <= ST_BUBBLE;
          r_finish    <= 1'b1;
          r_k         <= '0;
          r_l         <= '0;
          r_addr_k    <= '0;
          r_addr_l    <= '0;
          r_req_valid <= 1'b0;
          r_same_line <= 1'b0;
          r_mem_size  <= r_s1_mem_size;
          r_side      <= '0;
        end else begin
          r_status    <= ST_BCK_RUN;
          r_finish    <= 1'b0;
          r_k         <= w_k;
          r_l         <= w_l;
          r_addr_k    <= w_addr_k;
          r_addr_l    <= w_addr_l;
          r_req_valid <= 1'b1;
          r_same_line <= (w_addr_k == w_addr_l);
          r_mem_size  <= (r_s1_status == ST_BCK_INI) ? 7'd0 : r_s1_mem_size;
          r_side      <= r_s1_side;
        end
      end
    end
  end

  // Saturating count of memory lines requested, bumped on output handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_count <= '0;
    end else if (r_s2_v && out_ready && r_req_valid) begin
      r_req_count <= w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
    end
  end

  assign qry_valid     = r_qry_v;
  assign qry_read_num  = r_qry_read_num;
  assign qry_pos       = r_qry_pos;
  assign out_valid     = r_s2_v;
  assign out_status    = r_status;
  assign out_finish    = r_finish;
  assign out_read_num  = r_read_num;
  assign out_k         = r_k;
  assign out_l         = r_l;
  assign out_addr_k    = r_addr_k;
  assign out_addr_l    = r_addr_l;
  assign out_req_valid = r_req_valid;
  assign out_same_line = r_same_line;
  assign out_mem_size  = r_mem_size;
  assign out_side      = r_side;
  assign req_count     = r_req_count;

endmodule

// File: tb/tb_cal_kl_elastic.sv
// Directed bench for cal_kl_elastic: reset, INI/RUN/END decode, backpressure,
// dropped forward tokens and reset while tokens are in flight.
module tb_cal_kl_elastic;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [5:0]   in_status;
  logic         in_finish;
  logic [7:0]   in_read_num;
  logic [63:0]  in_x0, in_x2, in_primary;
  logic [6:0]   in_bwd_i, in_mem_wr_addr;
  logic [159:0] in_side;
  logic         qry_valid;
  logic [7:0]   qry_read_num;
  logic [6:0]   qry_pos;
  logic         out_valid, out_ready;
  logic [5:0]   out_status;
  logic         out_finish;
  logic [7:0]   out_read_num;
  logic [63:0]  out_k, out_l;
  logic [41:0]  out_addr_k, out_addr_l;
  logic         out_req_valid, out_same_line;
  logic [6:0]   out_mem_size;
  logic [159:0] out_side;
  logic [31:0]  req_count;

  int checks = 0;
  int failures = 0;

  cal_kl_elastic dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_status(in_status), .in_finish(in_finish),
    .in_read_num(in_read_num), .in_x0(in_x0), .in_x2(in_x2), .in_primary(in_primary),
    .in_bwd_i(in_bwd_i), .in_mem_wr_addr(in_mem_wr_addr), .in_side(in_side),
    .qry_valid(qry_valid), .qry_read_num(qry_read_num), .qry_pos(qry_pos),
    .out_valid(out_valid), .out_ready(out_ready), .out_status(out_status),
    .out_finish(out_finish), .out_read_num(out_read_num), .out_k(out_k), .out_l(out_l),
    .out_addr_k(out_addr_k), .out_addr_l(out_addr_l), .out_req_valid(out_req_valid),
    .out_same_line(out_same_line), .out_mem_size(out_mem_size), .out_side(out_side),
    .req_count(req_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tok(input logic [5:0] st, input logic fin, input logic [7:0] rn,
                         input logic [63:0] x0, input logic [63:0] x2, input logic [63:0] pri,
                         input logic [6:0] bwd, input logic [6:0] mwa, input logic [159:0] side);
    in_status = st; in_finish = fin; in_read_num = rn; in_x0 = x0; in_x2 = x2;
    in_primary = pri; in_bwd_i = bwd; in_mem_wr_addr = mwa; in_side = side;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_tok(6'h00, 1'b0, 8'h0, 64'h0, 64'h0, 64'h0, 7'h0, 7'h0, 160'h0);
    step(); step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
    checks++; if (out_status !== 6'h00) begin failures++; $display("FAIL rst_out_status got=%0h exp=0", out_status); end
    checks++; if (qry_valid !== 1'b0) begin failures++; $display("FAIL rst_qry_valid got=%0h exp=0", qry_valid); end
    checks++; if (req_count !== 32'h0) begin failures++; $display("FAIL rst_req_count got=%0h exp=0", req_count); end
    rst = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_bck_ini();
    set_tok(6'h08, 1'b0, 8'h11, 64'h100, 64'h10, 64'h50, 7'h22, 7'h09, 160'hBEEF);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (qry_valid !== 1'b1) begin failures++; $display("FAIL ini_qry_valid got=%0h exp=1", qry_valid); end
    checks++; if (qry_pos !== 7'h22) begin failures++; $display("FAIL ini_qry_pos got=%0h exp=22", qry_pos); end
    checks++; if (qry_read_num !== 8'h11) begin failures++; $display("FAIL ini_qry_read_num got=%0h exp=11", qry_read_num); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ini_early_valid got=%0h exp=0", out_valid); end
    step();
    checks++; if (qry_valid !== 1'b0) begin failures++; $display("FAIL ini_qry_pulse got=%0h exp=0", qry_valid); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ini_out_valid got=%0h exp=1", out_valid); end
    checks++; if (out_k !== 64'hFE) begin failures++; $display("FAIL ini_k got=%0h exp=fe", out_k); end
    checks++; if (out_l !== 64'h10E) begin failures++; $display("FAIL ini_l got=%0h exp=10e", out_l); end
    checks++; if (out_addr_k !== 42'h10) begin failures++; $display("FAIL ini_addr_k got=%0h exp=10", out_addr_k); end
    checks++; if (out_addr_l !== 42'h20) begin failures++; $display("FAIL ini_addr_l got=%0h exp=20", out_addr_l); end
    checks++; if (out_status !== 6'h10) begin failures++; $display("FAIL ini_status got=%0h exp=10", out_status); end
    checks++; if (out_mem_size !== 7'h0) begin failures++; $display("FAIL ini_mem_size got=%0h exp=0", out_mem_size); end
    checks++; if (out_same_line !== 1'b0) begin failures++; $display("FAIL ini_same_line got=%0h exp=0", out_same_line); end
    checks++; if (out_req_valid !== 1'b1) begin failures++; $display("FAIL ini_req_valid got=%0h exp=1", out_req_valid); end
    checks++; if (out_side !== 160'hBEEF) begin failures++; $display("FAIL ini_side got=%0h exp=beef", out_side); end
    step();
    checks++; if (req_count !== 32'd2) begin failures++; $display("FAIL ini_req_count got=%0d exp=2", req_count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ini_valid_drop got=%0h exp=0", out_valid); end
    $display("test_bck_ini done");
  endtask

  task automatic test_bck_run();
    set_tok(6'h10, 1'b0, 8'h05, 64'h81, 64'h10, 64'h1000, 7'h03, 7'h05, 160'h1234);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    checks++; if (out_k !== 64'h80) begin failures++; $display("FAIL run_k got=%0h exp=80", out_k); end
    checks++; if (out_l !== 64'h90) begin failures++; $display("FAIL run_l got=%0h exp=90", out_l); end
    checks++; if (out_addr_k !== 42'h10 || out_addr_l !== 42'h10) begin failures++; $display("FAIL run_addr got=%0h/%0h exp=10/10", out_addr_k, out_addr_l); end
    checks++; if (out_same_line !== 1'b1) begin failures++; $display("FAIL run_same_line got=%0h exp=1", out_same_line); end
    checks++; if (out_mem_size !== 7'd5) begin failures++; $display("FAIL run_mem_size got=%0h exp=5", out_mem_size); end
    checks++; if (out_side !== 160'h1234) begin failures++; $display("FAIL run_side got=%0h exp=1234", out_side); end
    step();
    checks++; if (req_count !== 32'd3) begin failures++; $display("FAIL run_req_count got=%0d exp=3", req_count); end
    $display("test_bck_run done");
  endtask

  task automatic test_bck_end();
    set_tok(6'h10, 1'b1, 8'h07, 64'h555, 64'h20, 64'h10, 7'h01, 7'h03, 160'hCAFE);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (qry_valid !== 1'b1) begin failures++; $display("FAIL end_qry_valid got=%0h exp=1", qry_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL end_out_valid got=%0h exp=1", out_valid); end
    checks++; if (out_status !== 6'h00) begin failures++; $display("FAIL end_status got=%0h exp=0", out_status); end
    checks++; if (out_finish !== 1'b1) begin failures++; $display("FAIL end_finish got=%0h exp=1", out_finish); end
    checks++; if (out_read_num !== 8'h07) begin failures++; $display("FAIL end_read_num got=%0h exp=7", out_read_num); end
    checks++; if (out_mem_size !== 7'd3) begin failures++; $display("FAIL end_mem_size got=%0h exp=3", out_mem_size); end
    checks++; if (out_req_valid !== 1'b0) begin failures++; $display("FAIL end_req_valid got=%0h exp=0", out_req_valid); end
    checks++; if (out_k !== 64'h0 || out_l !== 64'h0) begin failures++; $display("FAIL end_kl got=%0h/%0h exp=0/0", out_k, out_l); end
    checks++; if (out_addr_k !== 42'h0 || out_side !== 160'h0) begin failures++; $display("FAIL end_addr_side got=%0h/%0h exp=0/0", out_addr_k, out_side); end
    step();
    checks++; if (req_count !== 32'd3) begin failures++; $display("FAIL end_req_count got=%0d exp=3", req_count); end
    $display("test_bck_end done");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_tok(6'h10, 1'b0, 8'hA1, 64'h101, 64'h0, 64'h10000, 7'h0, 7'h01, 160'h0);
    in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_a got=%0h exp=1", in_ready); end
    step();
    set_tok(6'h10, 1'b0, 8'hA2, 64'h201, 64'h0, 64'h10000, 7'h0, 7'h02, 160'h0);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_b got=%0h exp=1", in_ready); end
    step();
    set_tok(6'h10, 1'b0, 8'hA3, 64'h301, 64'h0, 64'h10000, 7'h0, 7'h03, 160'h0);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%0h exp=0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_k !== 64'h100) begin failures++; $display("FAIL bp_hold0 got=%0h/%0h exp=1/100", out_valid, out_k); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (out_valid !== 1'b1 || out_k !== 64'h100 || out_read_num !== 8'hA1) begin failures++; $display("FAIL bp_hold got=%0h/%0h/%0h exp=1/100/a1", out_valid, out_k, out_read_num); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_hold got=%0h exp=0", in_ready); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_release got=%0h exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_k !== 64'h200) begin failures++; $display("FAIL bp_second got=%0h/%0h exp=1/200", out_valid, out_k); end
    step();
    checks++; if (out_valid !== 1'b1 || out_k !== 64'h300 || out_mem_size !== 7'd3) begin failures++; $display("FAIL bp_third got=%0h/%0h/%0h exp=1/300/3", out_valid, out_k, out_mem_size); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0h exp=0", out_valid); end
    checks++; if (req_count !== 32'd6) begin failures++; $display("FAIL bp_req_count got=%0d exp=6", req_count); end
    $display("test_backpressure done");
  endtask

  task automatic test_drop();
    set_tok(6'h02, 1'b0, 8'h09, 64'h400, 64'h4, 64'h1, 7'h05, 7'h01, 160'h0);
    in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL drop_in_ready got=%0h exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (qry_valid !== 1'b0) begin failures++; $display("FAIL drop_qry got=%0h exp=0", qry_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drop_out_valid got=%0h exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0 || req_count !== 32'd6) begin failures++; $display("FAIL drop_after got=%0h/%0d exp=0/6", out_valid, req_count); end
    $display("test_drop done");
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    set_tok(6'h10, 1'b0, 8'hB1, 64'h81, 64'h100, 64'h10000, 7'h0, 7'h01, 160'h0);
    in_valid = 1'b1;
    step();
    set_tok(6'h08, 1'b0, 8'hB2, 64'h81, 64'h100, 64'h10000, 7'h0, 7'h01, 160'h0);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%0h exp=1", out_valid); end
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%0h exp=0", out_valid); end
    checks++; if (qry_valid !== 1'b0) begin failures++; $display("FAIL mid_qry_valid got=%0h exp=0", qry_valid); end
    checks++; if (req_count !== 32'd0) begin failures++; $display("FAIL mid_req_count got=%0d exp=0", req_count); end
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (out_valid !== 1'b0 || req_count !== 32'd0) begin failures++; $display("FAIL mid_after got=%0h/%0d exp=0/0", out_valid, req_count); end
    end
    $display("test_reset_midflight done");
  endtask

  initial begin
    test_reset();
    test_bck_ini();
    test_bck_run();
    test_bck_end();
    test_backpressure();
    test_drop();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
